regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL expose the following parameters, one per line (name, default, meaning):
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count NREG = 2^ADDR_W.
- NREAD, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = none.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending.

REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; its ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk_i, in, 1, clock, rising edge.
- rst_n_i, in, 1, asynchronous active-low reset.
- raddr_i, in, NREAD*ADDR_W, read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- rdata_o, out, NREAD*DATA_W, read data, port k at bits [k*DATA_W +: DATA_W].
- busy_o, out, NREAD, read port k addresses a register with a pending write.
- we_i, in, 1, writeback enable.
- waddr_i, in, ADDR_W, writeback address.
- wdata_i, in, DATA_W, writeback data.
- issue_i, in, 1, an instruction targeting issue_rd_i has been issued.
- issue_rd_i, in, ADDR_W, destination of the issued instruction.
- flush_i, in, 1, discard all pending marks.
- pend_cnt_o, out, ADDR_W+1, number of registers currently pending.

Function
REQ-003 Register writes SHALL take effect at the rising clock edge when we_i=1; when ZERO_REG=1, writes to address 0 SHALL be ignored.
REQ-004 Each read port SHALL be combinational (zero latency): rdata_o[k] = reg[raddr[k]].
REQ-005 When ZERO_REG=1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-006 When BYPASS=1 and we_i=1 and waddr_i==raddr[k] (and the address is non-zero if ZERO_REG=1), rdata_o[k] SHALL equal wdata_i in the same cycle.
REQ-007 When BYPASS=0, a read SHALL return the pre-edge register value during the write cycle.
REQ-008 The block SHALL hold one pending bit per register; an edge with issue_i=1 SHALL set pend[issue_rd_i].
REQ-009 An edge with we_i=1 SHALL clear pend[waddr_i].
REQ-010 Set SHALL win over clear when issue_rd_i==waddr_i in the same cycle (back-to-back writers to one register).
REQ-011 flush_i=1 SHALL clear all pending bits at the edge; an issue in the same cycle SHALL still set its bit (flush, then set).
REQ-012 When ZERO_REG=1, pend[0] SHALL remain 0 under all inputs.
REQ-013 busy_o[k] = pend[raddr[k]], masked to 0 when BYPASS=1 and the same-cycle writeback matches the address under the conditions of REQ-006.
REQ-014 pend_cnt_o SHALL be a registered count of the set pending bits and SHALL equal the popcount of pend after every edge; it SHALL never wrap, since its maximum is NREG.
REQ-015 Register data SHALL be unaffected by issue_i and flush_i.

Reset
REQ-016 While rst_n_i=0, all registers, all pending bits and pend_cnt_o SHALL be 0 immediately, independent of clk_i.
REQ-017 Consequently, rdata_o=0 and busy_o=0 during reset, except for any bypass value of REQ-006.
REQ-018 Inputs SHALL be ignored while rst_n_i=0; reset asserted mid-operation SHALL discard all pending marks and register contents.
REQ-019 The first write SHALL be accepted at the first rising edge after rst_n_i deasserts.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (defaults unless stated):
- Write r5=0x1234_5678, then read port 0 at r5 on the next cycle -> 0x1234_5678; read r0 after we_i to r0 with 0xFFFF_FFFF -> 0.
- BYPASS=1: we_i to r7 with 0xA5A5_A5A5 while raddr port 1=7 -> same-cycle rdata_o port 1=0xA5A5_A5A5 and busy_o[1]=0. Repeat with BYPASS=0 -> old value.
- issue r3, then r3 read on the next cycle -> busy_o=1 and pend_cnt_o=1. Writeback r3 together with issue r3 in one cycle -> still busy, pend_cnt_o=1. Writeback r3 alone -> busy_o=0, pend_cnt_o=0.
- issue r1, r2, r4 on successive cycles -> pend_cnt_o=3. flush_i with issue r9 in the same cycle -> pend_cnt_o=1 and only r9 busy.
- Write r10=0x55, issue r11, then pulse rst_n_i low mid-cycle -> r10 reads 0 asynchronously, pend_cnt_o=0, busy_o=0.
- Random regression of issue, writeback and flush against a reference model -> pend_cnt_o equals the popcount every cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending scoreboard.
// Reads are combinational and can forward a same-cycle writeback. Each register
// has a pending bit: an issued instruction sets it and its writeback clears it.
// A registered count of the pending bits is also provided.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NREAD*ADDR_W-1:0]   raddr_i,
  output logic [NREAD*DATA_W-1:0]   rdata_o,
  output logic [NREAD-1:0]          busy_o,
  input  logic                      we_i,
  input  logic [ADDR_W-1:0]         waddr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic                      issue_i,
  input  logic [ADDR_W-1:0]         issue_rd_i,
  input  logic                      flush_i,
  output logic [ADDR_W:0]           pend_cnt_o
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;

  // A write to register 0 is dropped when it is hardwired to zero
  assign wr_ok = we_i && !((ZERO_REG != 0) && (waddr_i == '0));

  // Register storage: written on the clock edge, cleared by async reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  // Next pending vector: flush first, then writeback clear, then issue set,
  // so a new writer to the same register keeps it pending
  always_comb begin
    pend_nxt = flush_i ? '0 : pend;
    if (we_i) pend_nxt[waddr_i] = 1'b0;
    if (issue_i) pend_nxt[issue_rd_i] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  // Popcount of the next pending vector, so the registered count tracks pend
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  // Pending bits and their count, cleared by async reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend       <= '0;
      pend_cnt_o <= '0;
    end else begin
      pend       <= pend_nxt;
      pend_cnt_o <= cnt_nxt;
    end
  end

  // Combinational read ports with zero-register masking and optional forwarding
  always_comb begin
    rdata_o = '0;
    busy_o  = '0;
    for (int k = 0; k < NREAD; k++) begin
      if ((ZERO_REG != 0) && (raddr_i[k*ADDR_W +: ADDR_W] == '0)) begin
        rdata_o[k*DATA_W +: DATA_W] = '0;
        busy_o[k]                   = 1'b0;
      end else if ((BYPASS != 0) && we_i && (waddr_i == raddr_i[k*ADDR_W +: ADDR_W])) begin
        rdata_o[k*DATA_W +: DATA_W] = wdata_i;
        busy_o[k]                   = 1'b0;
      end else begin
        rdata_o[k*DATA_W +: DATA_W] = regs[raddr_i[k*ADDR_W +: ADDR_W]];
        busy_o[k]                   = pend[raddr_i[k*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule
